mem_dma_copy: RTL and testbench



---
 rtl/mem_dma_copy.sv | 117 +++++++++++
 tb/tb_mem_dma_copy.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dma_copy.sv
// Bus-initiator DMA that copies LEN words from SRC_ADDR to DST_ADDR, ascending, 3 cycles per word.
// Optional running checksum of copied words when DMA_COPY_CHECKSUM_EN is defined.
module mem_dma_copy #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC_ADDR,
  input  logic [ADDR_W-1:0] DST_ADDR,
  input  logic [LEN_W-1:0]  LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [LEN_W-1:0]  WORDS_DONE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              READ,
  output logic              WRITE,
  output logic [DATA_W-1:0] MEM_DATA_OUT,
  input  logic [DATA_W-1:0] MEM_DATA_IN,
  output logic [DATA_W-1:0] CHECKSUM
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;

  // MEM_DATA_OUT doubles as the word buffer: it is loaded at the end of
  // RD_WAIT and held until the next read completes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      remaining    <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      WORDS_DONE   <= '0;
      ADDR         <= '0;
      READ         <= 1'b0;
      WRITE        <= 1'b0;
      MEM_DATA_OUT <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            src_ptr    <= SRC_ADDR;
            dst_ptr    <= DST_ADDR;
            remaining  <= LEN;
            WORDS_DONE <= '0;
            if (LEN == '0) begin
              DONE <= 1'b1;
            end else begin
              state <= RD_REQ;
              BUSY  <= 1'b1;
              READ  <= 1'b1;
              ADDR  <= SRC_ADDR;
            end
          end
        end
        RD_REQ: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          MEM_DATA_OUT <= MEM_DATA_IN;
          READ         <= 1'b0;
          WRITE        <= 1'b1;
          ADDR         <= dst_ptr;
          state        <= WR;
        end
        WR: begin
          WRITE      <= 1'b0;
          WORDS_DONE <= WORDS_DONE + LEN_W'(1);
          src_ptr    <= src_ptr + ADDR_W'(1);
          dst_ptr    <= dst_ptr + ADDR_W'(1);
          remaining  <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            state <= RD_REQ;
            READ  <= 1'b1;
            ADDR  <= src_ptr + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          READ  <= 1'b0;
          WRITE <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMA_COPY_CHECKSUM_EN
  // Sum accumulates the word being written, so it is final in the DONE cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CHECKSUM <= '0;
    end else if (state == IDLE && START) begin
      CHECKSUM <= '0;
    end else if (state == WR) begin
      CHECKSUM <= CHECKSUM + MEM_DATA_OUT;
    end
  end
`else
  assign CHECKSUM = '0;
`endif

endmodule

// File: tb/tb_mem_dma_copy.sv
// Directed self-checking bench for mem_dma_copy with a 4K-word behavioural memory.
// Expected checksums follow DMA_COPY_CHECKSUM_EN when it is defined for the build.
module tb_mem_dma_copy;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_done;
  logic [ADDR_W-1:0] addr;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] checksum;

  mem_dma_copy #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .CLK(clk), .RST(rst), .START(start), .SRC_ADDR(src_addr), .DST_ADDR(dst_addr),
    .LEN(len), .BUSY(busy), .DONE(done), .WORDS_DONE(words_done), .ADDR(addr),
    .READ(read), .WRITE(write), .MEM_DATA_OUT(mem_data_out), .MEM_DATA_IN(mem_data_in),
    .CHECKSUM(checksum)
  );

  always #5 clk = ~clk;

  // Memory aliases on the low 12 address bits; read data is combinational.
  logic [DATA_W-1:0] mem [0:4095];
  assign mem_data_in = mem[addr[11:0]];

  int vectors = 0;
  int miscompares = 0;
  int read_pulses, write_count, done_pulses, lat;
  bit busy_seen;
  logic prev_read = 1'b0;
  logic [ADDR_W-1:0] rd_log [$];
  logic [ADDR_W-1:0] wr_log [$];

`ifdef DMA_COPY_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  function automatic logic [63:0] csum(input logic [31:0] value);
    return CSUM_ON ? 64'(value) : 64'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every cycle passes through here: bus overlap check, logging, memory writes.
  task automatic tick();
    @(negedge clk);
    vectors++;
    assert (!(read && write)) else begin
      miscompares++;
      $error("[TB] FAIL rw_overlap: observed READ=%0b WRITE=%0b, expected not both 1", read, write);
    end
    if (read && !prev_read) begin
      read_pulses++;
      rd_log.push_back(addr);
    end
    prev_read = read;
    if (write) begin
      write_count++;
      wr_log.push_back(addr);
      mem[addr[11:0]] = mem_data_out;
    end
    if (done) done_pulses++;
    if (busy) busy_seen = 1'b1;
  endtask

  task automatic clearLogs();
    read_pulses = 0;
    write_count = 0;
    done_pulses = 0;
    busy_seen   = 1'b0;
    rd_log.delete();
    wr_log.delete();
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] l);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = l;
    tick();
    start = 1'b0;
  endtask

  // latency counts clock edges from the START edge to the edge that samples DONE=1.
  task automatic waitDone(input int first, input int budget, output int latency);
    latency = first;
    while (!done && latency < budget) begin
      tick();
      latency++;
    end
    checkOutput("done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    clearLogs();
    #2;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_rw", {62'd0, read, write}, 64'd0);
    checkOutput("reset_addr", 64'(addr), 64'd0);
    checkOutput("reset_words", 64'(words_done), 64'd0);
    checkOutput("reset_csum", 64'(checksum), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] basic copy of 4 words");
    for (int i = 0; i < 4; i++) mem[12'h100 + i] = 32'(i + 1);
    clearLogs();
    applyStimulus(26'h100, 26'h200, 16'd4);
    waitDone(1, 60, lat);
    checkOutput("basic_latency", 64'(lat), 64'd13);
    checkOutput("basic_busy_at_done", 64'(busy), 64'd0);
    checkOutput("basic_words", 64'(words_done), 64'd4);
    checkOutput("basic_csum", 64'(checksum), csum(32'd10));
    tick(); tick();
    checkOutput("basic_done_pulses", 64'(done_pulses), 64'd1);
    checkOutput("basic_mem200", 64'(mem[12'h200]), 64'd1);
    checkOutput("basic_mem201", 64'(mem[12'h201]), 64'd2);
    checkOutput("basic_mem202", 64'(mem[12'h202]), 64'd3);
    checkOutput("basic_mem203", 64'(mem[12'h203]), 64'd4);
    checkOutput("basic_writes", 64'(write_count), 64'd4);
    checkOutput("basic_reads", 64'(read_pulses), 64'd4);

    $display("[TB] zero length");
    clearLogs();
    applyStimulus(26'h100, 26'h300, 16'd0);
    waitDone(1, 5, lat);
    checkOutput("zero_latency", 64'(lat), 64'd1);
    tick(); tick(); tick();
    checkOutput("zero_reads", 64'(read_pulses), 64'd0);
    checkOutput("zero_writes", 64'(write_count), 64'd0);
    checkOutput("zero_busy_seen", 64'(busy_seen), 64'd0);
    checkOutput("zero_done_pulses", 64'(done_pulses), 64'd1);
    checkOutput("zero_words", 64'(words_done), 64'd0);
    checkOutput("zero_csum", 64'(checksum), 64'd0);

    $display("[TB] address wrap");
    mem[12'hFFF] = 32'hAA;
    mem[12'h000] = 32'hBB;
    clearLogs();
    applyStimulus(26'h3FFFFFF, 26'h10, 16'd2);
    waitDone(1, 30, lat);
    checkOutput("wrap_latency", 64'(lat), 64'd7);
    checkOutput("wrap_csum", 64'(checksum), csum(32'h165));
    tick();
    checkOutput("wrap_rd0", 64'(rd_log[0]), 64'h3FFFFFF);
    checkOutput("wrap_rd1", 64'(rd_log[1]), 64'h0);
    checkOutput("wrap_wr0", 64'(wr_log[0]), 64'h10);
    checkOutput("wrap_wr1", 64'(wr_log[1]), 64'h11);
    checkOutput("wrap_mem10", 64'(mem[12'h010]), 64'hAA);
    checkOutput("wrap_mem11", 64'(mem[12'h011]), 64'hBB);

    $display("[TB] START while busy is ignored");
    mem[12'h300] = 32'h11; mem[12'h301] = 32'h22; mem[12'h302] = 32'h33;
    for (int i = 0; i < 5; i++) mem[12'h500 + i] = 32'h55;
    clearLogs();
    applyStimulus(26'h300, 26'h400, 16'd3);
    tick(); tick(); tick();
    start = 1'b1; src_addr = 26'h500; dst_addr = 26'h600; len = 16'd5;
    tick();
    start = 1'b0;
    waitDone(5, 40, lat);
    checkOutput("busy_latency", 64'(lat), 64'd10);
    checkOutput("busy_words", 64'(words_done), 64'd3);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("busy_done_pulses", 64'(done_pulses), 64'd1);
    checkOutput("busy_writes", 64'(write_count), 64'd3);
    checkOutput("busy_last_wr", 64'(wr_log[2]), 64'h402);
    checkOutput("busy_mem402", 64'(mem[12'h402]), 64'h33);
    checkOutput("busy_mem600", 64'(mem[12'h600]), 64'h0);

    $display("[TB] reset during second word");
    for (int i = 0; i < 4; i++) mem[12'h700 + i] = 32'(32'h70 + i);
    clearLogs();
    applyStimulus(26'h700, 26'h800, 16'd4);
    tick(); tick(); tick(); tick();
    checkOutput("rst_pre_read", 64'(read), 64'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_read", 64'(read), 64'd0);
    checkOutput("rst_write", 64'(write), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_words", 64'(words_done), 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();
    checkOutput("rst_done_pulses", 64'(done_pulses), 64'd0);
    checkOutput("rst_writes", 64'(write_count), 64'd1);
    checkOutput("rst_mem800", 64'(mem[12'h800]), 64'h70);
    checkOutput("rst_mem801", 64'(mem[12'h801]), 64'h0);
    clearLogs();
    applyStimulus(26'h700, 26'h900, 16'd4);
    waitDone(1, 60, lat);
    checkOutput("after_rst_latency", 64'(lat), 64'd13);
    checkOutput("after_rst_words", 64'(words_done), 64'd4);
    checkOutput("after_rst_csum", 64'(checksum), csum(32'h1C6));
    tick();
    checkOutput("after_rst_mem900", 64'(mem[12'h900]), 64'h70);
    checkOutput("after_rst_mem903", 64'(mem[12'h903]), 64'h73);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
